hist_stats: RTL and testbench
=============================

HIST_STATS -- requirements
Module: hist_stats

Interface
REQ-001 Parameter: IDX_W, 8, bin index width; at most 2^IDX_W bins per frame.
REQ-002 Parameter: CNT_W, 8, bin count width, matching the histogram stage's data_out.
REQ-003 Parameter: SUM_W, 16, total-count accumulator width.
REQ-004 Port: clk  input  1  the only clock; all logic updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: bin_data  input  CNT_W  count of the current bin, from the histogram stage's data_out.
REQ-007 Port: bin_valid  input  1  bin_data is valid this cycle (the histogram stage's valid_out).
REQ-008 Port: bin_last  input  1  the current beat is the final bin of a frame (the histogram stage's last_bin); ignored when bin_valid=0.
REQ-009 Port: in_ready  output  1  block accepts a bin beat this cycle.
REQ-010 Port: result_valid  output  1  the result fields hold a complete frame summary.
REQ-011 Port: result_ready  input  1  the consumer takes the summary.
REQ-012 Port: peak_index  output  IDX_W  index of the bin holding the largest count.
REQ-013 Port: peak_count  output  CNT_W  the largest count.
REQ-014 Port: total_count  output  SUM_W  saturating sum of all bin counts.
REQ-015 Port: nonzero_bins  output  IDX_W+1  number of bins with a count greater than 0.
REQ-016 Port: overrun_err  output  1  sticky error flag: a beat arrived while in_ready=0, or a frame exceeded 2^IDX_W bins.

Function
REQ-017 The block SHALL implement the states COLLECT and REPORT only; reset enters COLLECT.
REQ-018 in_ready SHALL be 1 in COLLECT and 0 in REPORT, decoded from registered state only.
REQ-019 A beat SHALL be accepted when bin_valid=1 and in_ready=1.
REQ-020 Each accepted beat SHALL increment the bin index counter, which starts at 0 for each frame.
REQ-021 Each accepted beat SHALL add bin_data to the sum, saturating at 2^SUM_W-1.
REQ-022 Each accepted beat with bin_data!=0 SHALL increment the nonzero counter.
REQ-023 Peak update SHALL occur only when bin_data is strictly greater than the current peak, so the first occurrence wins ties.
REQ-024 The peak register SHALL start each frame at count 0, index 0; an all-zero frame therefore reports peak_index 0 and peak_count 0.
REQ-025 An accepted beat with bin_last=1 SHALL move the FSM to REPORT on the next edge.
REQ-026 Results SHALL include the last beat, and result_valid SHALL rise exactly 1 cycle after the last beat is accepted.
REQ-027 In REPORT, result_valid SHALL stay 1 and all result fields SHALL stay stable until result_valid=1 and result_ready=1 coincide on a clock edge.
REQ-028 On that handshake edge the FSM SHALL return to COLLECT and clear the accumulators, so in_ready=1 on the following cycle.
REQ-029 The result fields SHALL be registered copies; accumulators clearing SHALL NOT disturb them while result_valid=1.
REQ-030 A beat with bin_valid=1 while in_ready=0 SHALL be dropped and SHALL set overrun_err.
REQ-031 If the index counter has already counted 2^IDX_W beats without bin_last, then further beats SHALL set overrun_err.
REQ-032 In that case the index counter SHALL hold at its maximum, while accumulation continues.
REQ-033 overrun_err SHALL clear only on reset.
REQ-034 result_valid SHALL be 0 in COLLECT.

Reset
REQ-035 Reset SHALL force state=COLLECT and all counters and accumulators to 0.
REQ-036 Reset SHALL force peak_index, peak_count, total_count and nonzero_bins to 0.
REQ-037 Reset SHALL force result_valid=0, overrun_err=0 and in_ready=1 in the cycle after reset is sampled.
REQ-038 Reset asserted mid-frame or during REPORT SHALL discard the partial frame or pending result entirely; reset has priority over every other event.

Structure
REQ-039 The package hist_pkg SHALL hold the IDX_W, CNT_W and SUM_W defaults and the FSM state type.
REQ-040 A single sub-module, hist_sat_add (saturating SUM_W adder with zero-extended CNT_W operand), SHALL be used for the total accumulator.

Verification
REQ-041 Frame 3,7,2,7 (last on the 4th beat), result_ready=1 SHALL give peak_index=1, peak_count=7, total_count=19, nonzero_bins=4, with result_valid 1 cycle after the last beat.
REQ-042 Frame of 4 zeros SHALL give peak_index=0, peak_count=0, total_count=0, nonzero_bins=0.
REQ-043 Frame of 256 beats of 255, last on the 256th, with SUM_W=16 SHALL give total_count=65280; a repeat with SUM_W=15 SHALL give total_count=32767 (saturated).
REQ-044 With result_ready held 0 for 5 cycles, a beat during REPORT SHALL be dropped, set overrun_err=1 and keep the results unchanged; the next frame SHALL start clean after result_ready=1.
REQ-045 Reset asserted after 2 beats of a frame, then a frame 5,9 SHALL report peak_index=1, peak_count=9, total_count=14, nonzero_bins=2.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared defaults and FSM state type for the histogram statistics block.
package hist_pkg;

    localparam int HIST_IDX_W = 8;
    localparam int HIST_CNT_W = 8;
    localparam int HIST_SUM_W = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

endpackage

// File: rtl/hist_stats_if.sv
// Bin stream in, frame summary out. master = producer/consumer side, slave = hist_stats.
interface hist_stats_if
    import hist_pkg::*;
#(
    parameter int IDX_W = HIST_IDX_W,
    parameter int CNT_W = HIST_CNT_W,
    parameter int SUM_W = HIST_SUM_W
);
    logic [CNT_W-1:0] bin_data;
    logic             bin_valid;
    logic             bin_last;
    logic             in_ready;
    logic             result_valid;
    logic             result_ready;
    logic [IDX_W-1:0] peak_index;
    logic [CNT_W-1:0] peak_count;
    logic [SUM_W-1:0] total_count;
    logic [IDX_W:0]   nonzero_bins;
    logic             overrun_err;

    modport master (
        output bin_data, bin_valid, bin_last, result_ready,
        input  in_ready, result_valid, peak_index, peak_count,
               total_count, nonzero_bins, overrun_err
    );

    modport slave (
        input  bin_data, bin_valid, bin_last, result_ready,
        output in_ready, result_valid, peak_index, peak_count,
               total_count, nonzero_bins, overrun_err
    );
endinterface

// File: rtl/hist_sat_add.sv
// Saturating adder: SUM_W accumulator plus a zero-extended CNT_W count.
module hist_sat_add #(
    parameter int SUM_W = 16,
    parameter int CNT_W = 8
) (
    input  logic [SUM_W-1:0] a,
    input  logic [CNT_W-1:0] b,
    output logic [SUM_W-1:0] y
);
    logic [SUM_W:0] sum;

    assign sum = {1'b0, a} + (SUM_W+1)'(b);
    assign y   = sum[SUM_W] ? '1 : sum[SUM_W-1:0];
endmodule

// File: rtl/hist_stats.sv
// Per-frame histogram summary: peak bin, saturating total, nonzero-bin count.
module hist_stats
    import hist_pkg::*;
#(
    parameter int IDX_W = HIST_IDX_W,
    parameter int CNT_W = HIST_CNT_W,
    parameter int SUM_W = HIST_SUM_W
) (
    input  logic       clk,
    input  logic       reset,
    hist_stats_if.slave bus
);
    typedef struct packed {
        logic [IDX_W-1:0] peak_index;
        logic [CNT_W-1:0] peak_count;
        logic [SUM_W-1:0] total;
        logic [IDX_W:0]   nonzero;
    } res_t;

    state_t           state, state_nxt;
    res_t             acc, acc_nxt, res;
    logic [IDX_W:0]   idx_cnt;
    logic             idx_full;
    logic [IDX_W-1:0] cur_idx;
    logic [SUM_W-1:0] sum_nxt;
    logic             in_rdy;
    logic             accept;
    logic             overrun;

    assign in_rdy   = (state == COLLECT);
    assign accept   = bus.bin_valid && in_rdy;
    // idx_cnt MSB set means 2^IDX_W beats already seen in this frame
    assign idx_full = idx_cnt[IDX_W];
    assign cur_idx  = idx_full ? '1 : idx_cnt[IDX_W-1:0];

    hist_sat_add #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_sat_add (
        .a (acc.total),
        .b (bus.bin_data),
        .y (sum_nxt)
    );

    always_comb begin
        acc_nxt       = acc;
        acc_nxt.total = sum_nxt;
        if (bus.bin_data != '0 && acc.nonzero != '1)
            acc_nxt.nonzero = acc.nonzero + (IDX_W+1)'(1);
        // strict compare keeps the first occurrence on ties
        if (bus.bin_data > acc.peak_count) begin
            acc_nxt.peak_count = bus.bin_data;
            acc_nxt.peak_index = cur_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && bus.bin_last) state_nxt = REPORT;
            REPORT:  if (bus.result_ready)       state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_cnt <= '0;
            acc     <= '0;
            res     <= '0;
            overrun <= 1'b0;
        end else begin
            if ((bus.bin_valid && !in_rdy) || (accept && idx_full))
                overrun <= 1'b1;
            if (accept) begin
                acc <= acc_nxt;
                if (!idx_full) idx_cnt <= idx_cnt + (IDX_W+1)'(1);
                if (bus.bin_last) res <= acc_nxt;
            end
            if (state == REPORT && bus.result_ready) begin
                acc     <= '0;
                idx_cnt <= '0;
            end
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.result_valid = (state == REPORT);
    assign bus.peak_index   = res.peak_index;
    assign bus.peak_count   = res.peak_count;
    assign bus.total_count  = res.total;
    assign bus.nonzero_bins = res.nonzero;
    assign bus.overrun_err  = overrun;
endmodule

// File: tb/tb_hist_stats.sv
// Scoreboard bench: two instances (SUM_W 16 and 15) fed identical bin streams.
module tb_hist_stats;
    typedef struct {
        int pi;
        int pc;
        int tc;
        int nz;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bin_data = '0;
    logic       bin_valid = 1'b0;
    logic       bin_last = 1'b0;
    logic       result_ready = 1'b1;

    int   total = 0;
    int   bad = 0;
    exp_t q16[$];
    exp_t q15[$];
    exp_t e16, e15;
    int   fr[$];

    hist_stats_if #(.IDX_W(8), .CNT_W(8), .SUM_W(16)) bus16 ();
    hist_stats_if #(.IDX_W(8), .CNT_W(8), .SUM_W(15)) bus15 ();

    assign bus16.bin_data = bin_data;
    assign bus16.bin_valid = bin_valid;
    assign bus16.bin_last = bin_last;
    assign bus16.result_ready = result_ready;
    assign bus15.bin_data = bin_data;
    assign bus15.bin_valid = bin_valid;
    assign bus15.bin_last = bin_last;
    assign bus15.result_ready = result_ready;

    hist_stats #(.IDX_W(8), .CNT_W(8), .SUM_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
    hist_stats #(.IDX_W(8), .CNT_W(8), .SUM_W(15)) u_dut15 (.clk(clk), .reset(reset), .bus(bus15));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference model fills both scoreboards, then streams fr[] back to back.
    task automatic run_frame();
        exp_t m16, m15;
        int pk = 0, pi = 0, s16 = 0, s15 = 0, nz = 0;
        foreach (fr[i]) begin
            if (fr[i] > pk) begin
                pk = fr[i];
                pi = (i < 256) ? i : 255;
            end
            s16 = (s16 + fr[i] > 65535) ? 65535 : s16 + fr[i];
            s15 = (s15 + fr[i] > 32767) ? 32767 : s15 + fr[i];
            if (fr[i] != 0) nz++;
        end
        m16 = '{pi, pk, s16, nz};
        m15 = '{pi, pk, s15, nz};
        q16.push_back(m16);
        q15.push_back(m15);
        foreach (fr[i]) begin
            bin_data  = 8'(fr[i]);
            bin_valid = 1'b1;
            bin_last  = (i == fr.size() - 1);
            @(posedge clk); #1;
            if (i != fr.size() - 1) chk("rv_low", 32'(bus16.result_valid), 0);
        end
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        chk("rv_lat", 32'(bus16.result_valid), 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && (q16.size() != 0 || q15.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain", 32'(q16.size() + q15.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus16.result_valid && result_ready) begin
            if (q16.size() == 0) chk("sb16_empty", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("pi16", 32'(bus16.peak_index), e16.pi);
                chk("pc16", 32'(bus16.peak_count), e16.pc);
                chk("tc16", 32'(bus16.total_count), e16.tc);
                chk("nz16", 32'(bus16.nonzero_bins), e16.nz);
            end
        end
        if (!reset && bus15.result_valid && result_ready) begin
            if (q15.size() == 0) chk("sb15_empty", 1, 0);
            else begin
                e15 = q15.pop_front();
                chk("pi15", 32'(bus15.peak_index), e15.pi);
                chk("tc15", 32'(bus15.total_count), e15.tc);
                chk("nz15", 32'(bus15.nonzero_bins), e15.nz);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus16.in_ready), 1);
        chk("rst_rv", 32'(bus16.result_valid), 0);
        chk("rst_ovr", 32'(bus16.overrun_err), 0);
        chk("rst_fields", 32'(bus16.peak_index) + bus16.peak_count + bus16.total_count + bus16.nonzero_bins, 0);
        reset = 1'b0;

        // peak tie keeps first occurrence
        fr = '{3, 7, 2, 7};
        run_frame();
        wait_drain();

        fr = '{0, 0, 0, 0};
        run_frame();
        wait_drain();

        // stalled consumer: beat during REPORT is dropped
        result_ready = 1'b0;
        fr = '{1, 2};
        run_frame();
        repeat (2) @(posedge clk);
        #1;
        bin_data = 8'd50; bin_valid = 1'b1; bin_last = 1'b1;
        @(posedge clk); #1;
        bin_valid = 1'b0; bin_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_set", 32'(bus16.overrun_err), 1);
        chk("ovr_in_ready", 32'(bus16.in_ready), 0);
        chk("hold_rv", 32'(bus16.result_valid), 1);
        chk("hold_pi", 32'(bus16.peak_index), 1);
        chk("hold_pc", 32'(bus16.peak_count), 2);
        chk("hold_tc", 32'(bus16.total_count), 3);
        chk("hold_nz", 32'(bus16.nonzero_bins), 2);
        result_ready = 1'b1;
        wait_drain();
        chk("post_hs_in_ready", 32'(bus16.in_ready), 1);
        fr = '{4, 0, 6};
        run_frame();
        wait_drain();
        chk("ovr_sticky", 32'(bus16.overrun_err), 1);

        // reset mid-frame discards the partial frame and the sticky error
        bin_data = 8'd100; bin_valid = 1'b1;
        @(posedge clk); #1;
        bin_data = 8'd200;
        @(posedge clk); #1;
        bin_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ovr", 32'(bus16.overrun_err), 0);
        chk("mid_rst_in_ready", 32'(bus16.in_ready), 1);
        chk("mid_rst_tc", 32'(bus16.total_count), 0);
        reset = 1'b0;
        fr = '{5, 9};
        run_frame();
        wait_drain();

        // full-size frame: 65280 fits SUM_W=16, saturates SUM_W=15
        fr.delete();
        for (int i = 0; i < 256; i++) fr.push_back(255);
        run_frame();
        wait_drain();
        chk("ovr_256", 32'(bus16.overrun_err), 0);

        // 258 beats: index counter overflow flags overrun, accumulation continues
        fr.delete();
        for (int i = 0; i < 258; i++) fr.push_back(i == 10 ? 9 : 1);
        run_frame();
        wait_drain();
        chk("ovr_idx", 32'(bus16.overrun_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
